// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the add/sub ALU: captures decoded operands,
// forwards results from EX/MEM and MEM/WB, and detects load-use hazards.
module id_ex_operand_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RA-1:0] id_rs_addr,
    input  logic [RA-1:0] id_rt_addr,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [W-1:0]  id_imm,
    input  logic          id_alusrc,
    input  logic          id_op,
    input  logic          id_sign,
    input  logic [RA-1:0] id_rd_addr,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          exmem_regwrite,
    input  logic [RA-1:0] exmem_rd,
    input  logic [W-1:0]  exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RA-1:0] memwb_rd,
    input  logic [W-1:0]  memwb_data,
    input  logic          flush,
    input  logic          hold,
    output logic [W-1:0]  alu_A,
    output logic [W-1:0]  alu_B,
    output logic          alu_op,
    output logic          alu_sign,
    output logic          ex_valid,
    output logic [RA-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          id_stall
);

    logic          valid_q;
    logic [RA-1:0] rs_addr_q, rt_addr_q, rd_q;
    logic [W-1:0]  rs_data_q, rt_data_q, imm_q;
    logic          alusrc_q, op_q, sign_q, regwrite_q, memread_q;
    logic          luh;

    // $0 is hard-wired zero, so a pending write to it must never be forwarded.
    function automatic logic [W-1:0] forward(
        input logic [RA-1:0] src_addr,
        input logic [W-1:0]  raw,
        input logic          em_we,
        input logic [RA-1:0] em_rd,
        input logic [W-1:0]  em_val,
        input logic          mw_we,
        input logic [RA-1:0] mw_rd,
        input logic [W-1:0]  mw_val
    );
        logic [W-1:0] result;
        // NOTE: default assignment first so no path through the block leaves result unassigned.
        result = raw;
        if (em_we && em_rd != '0 && em_rd == src_addr)
            result = em_val;
        else if (mw_we && mw_rd != '0 && mw_rd == src_addr)
            result = mw_val;
        return result;
    endfunction

    assign luh = valid_q & memread_q & (rd_q != '0) & id_valid &
                 ((id_uses_rs & (id_rs_addr == rd_q)) | (id_uses_rt & (id_rt_addr == rd_q)));

    assign id_stall = hold | (luh & ~flush);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            rd_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            op_q       <= 1'b0;
            sign_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else if (flush || (!hold && luh)) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid_q    <= 1'b0;
            op_q       <= 1'b0;
            sign_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else if (!hold) begin
            valid_q    <= id_valid;
            rs_addr_q  <= id_rs_addr;
            rt_addr_q  <= id_rt_addr;
            rd_q       <= id_rd_addr;
            rs_data_q  <= id_rs_data;
            rt_data_q  <= id_rt_data;
            imm_q      <= id_imm;
            alusrc_q   <= id_alusrc;
            op_q       <= id_op;
            sign_q     <= id_sign;
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
        end
    end

    always_comb begin
        alu_A = forward(rs_addr_q, rs_data_q, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_data);
        alu_B = alusrc_q ? imm_q
                         : forward(rt_addr_q, rt_data_q, exmem_regwrite, exmem_rd, exmem_result,
                                   memwb_regwrite, memwb_rd, memwb_data);
    end

    assign alu_op      = op_q;
    assign alu_sign    = sign_q;
    assign ex_valid    = valid_q;
    assign ex_rd       = rd_q;
    assign ex_regwrite = valid_q & regwrite_q;
    assign ex_memread  = valid_q & memread_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding, load-use stall,
// immediate path, hold and flush, with hand-computed expected values.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs, id_uses_rt, id_alusrc, id_op, id_sign;
    logic        id_regwrite, id_memread;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;
    logic        flush, hold;
    logic [31:0] alu_A, alu_B;
    logic        alu_op, alu_sign, ex_valid, ex_regwrite, ex_memread, id_stall;
    logic [4:0]  ex_rd;

    int vectors = 0;
    int miscompares = 0;

    id_ex_operand_stage #(.W(32), .RA(5)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_op(id_op), .id_sign(id_sign),
        .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush), .hold(hold),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_sign(alu_sign),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .id_stall(id_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change in the same window.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm, input logic asrc,
                          input logic op, input logic sgn, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v;  id_rs_addr = rs;  id_rt_addr = rt;  id_uses_rs = urs;
        id_uses_rt = urt;  id_rs_data = rsd;  id_rt_data = rtd;  id_imm = imm;
        id_alusrc = asrc;  id_op = op;  id_sign = sgn;  id_rd_addr = rd;
        id_regwrite = rw;  id_memread = mr;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;  hold = 1'b0;
        exmem_regwrite = 1'b0;  exmem_rd = '0;  exmem_result = '0;
        memwb_regwrite = 1'b0;  memwb_rd = '0;  memwb_data = '0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset state
        tick();
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_alu_A", alu_A, 32'd0);
        check("rst_alu_B", alu_B, 32'd0);
        check("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
        reset = 1'b1;

        // First capture, then asynchronous reset mid-cycle
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'd3, 32'd5, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        check("cap_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("cap_alu_A", alu_A, 32'd3);
        check("cap_ex_regwrite", {31'b0, ex_regwrite}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("async_rst_alu_A", alu_A, 32'd0);
        check("async_rst_alu_op", {31'b0, alu_op}, 32'd0);
        check("async_rst_ex_regwrite", {31'b0, ex_regwrite}, 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_alu_A", alu_A, 32'd3);
        check("post_rst_alu_B", alu_B, 32'd5);
        check("post_rst_alu_op", {31'b0, alu_op}, 32'd1);
        check("post_rst_alu_sign", {31'b0, alu_sign}, 32'd1);
        check("post_rst_ex_valid", {31'b0, ex_valid}, 32'd1);

        // Forwarding priority on A and B
        set_id(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 32'h55, 32'h66, 32'h0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
        tick();
        exmem_regwrite = 1'b1;  exmem_rd = 5'd8;  exmem_result = 32'h10;
        memwb_regwrite = 1'b1;  memwb_rd = 5'd8;  memwb_data = 32'h20;
        #1;
        check("fwd_exmem_beats_memwb", alu_A, 32'h10);
        check("fwd_B_no_match", alu_B, 32'h66);
        exmem_rd = 5'd0;  memwb_rd = 5'd0;
        #1;
        check("fwd_r0_ignored", alu_A, 32'h55);
        exmem_rd = 5'd5;  memwb_rd = 5'd8;
        #1;
        check("fwd_memwb_only", alu_A, 32'h20);
        exmem_regwrite = 1'b0;  exmem_rd = 5'd3;  memwb_rd = 5'd3;
        #1;
        check("fwd_B_memwb_exmem_nowrite", alu_B, 32'h20);
        exmem_regwrite = 1'b1;
        #1;
        check("fwd_B_exmem", alu_B, 32'h10);
        exmem_regwrite = 1'b0;  memwb_regwrite = 1'b0;

        // Load-use hazard: load to $9 in EX, dependent instruction in ID
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        check("load_ex_memread", {31'b0, ex_memread}, 32'd1);
        set_id(1'b1, 5'd1, 5'd9, 1'b0, 1'b0, 32'h1, 32'h2, 32'h4, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
        #1;
        check("luh_alusrc_no_stall", {31'b0, id_stall}, 32'd0);
        id_uses_rt = 1'b1;  id_alusrc = 1'b0;
        #1;
        check("luh_stall", {31'b0, id_stall}, 32'd1);
        tick();
        check("luh_bubble_valid", {31'b0, ex_valid}, 32'd0);
        check("luh_bubble_regwrite", {31'b0, ex_regwrite}, 32'd0);
        check("luh_bubble_memread", {31'b0, ex_memread}, 32'd0);
        check("luh_stall_one_cycle", {31'b0, id_stall}, 32'd0);
        tick();
        check("luh_retry_valid", {31'b0, ex_valid}, 32'd1);
        check("luh_retry_rd", {27'b0, ex_rd}, 32'd10);

        // Immediate path ignores forwarding
        set_id(1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 32'h77, 32'h12, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
        tick();
        exmem_regwrite = 1'b1;  exmem_rd = 5'd7;  exmem_result = 32'hABC;
        #1;
        check("imm_no_fwd", alu_B, 32'hFFFF_FFFF);
        check("imm_alu_A", alu_A, 32'h77);

        // Hold for three cycles with changing ID inputs
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd4, 5'd6, 1'b1, 1'b1, 32'h100 + i, 32'h200 + i, 32'h0, 1'b0, 1'b1, 1'b1,
                   5'd20 + 5'(i), 1'b1, 1'b0);
            #1;
            check("hold_stall", {31'b0, id_stall}, 32'd1);
            tick();
            check("hold_alu_A", alu_A, 32'h77);
            check("hold_alu_B", alu_B, 32'hFFFF_FFFF);
            check("hold_ex_rd", {27'b0, ex_rd}, 32'd11);
        end
        hold = 1'b0;
        set_id(1'b1, 5'd2, 5'd6, 1'b1, 1'b1, 32'h99, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
        tick();
        check("release_alu_A", alu_A, 32'h99);
        check("release_alu_B", alu_B, 32'h44);
        check("release_ex_rd", {27'b0, ex_rd}, 32'd12);

        // Flush beats hold
        flush = 1'b1;  hold = 1'b1;
        #1;
        check("flush_hold_stall", {31'b0, id_stall}, 32'd1);
        tick();
        check("flush_hold_valid", {31'b0, ex_valid}, 32'd0);
        check("flush_hold_regwrite", {31'b0, ex_regwrite}, 32'd0);

        // Flush together with a load-use hazard
        flush = 1'b0;  hold = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
        #1;
        check("luh_rs_stall", {31'b0, id_stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_luh_no_stall", {31'b0, id_stall}, 32'd0);
        tick();
        check("flush_luh_valid", {31'b0, ex_valid}, 32'd0);
        check("flush_luh_memread", {31'b0, ex_memread}, 32'd0);
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
